// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe gap scheduler and its LFSR.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      OFFER
   } state_t;

   localparam int unsigned GAP_Y_W      = 10;
   localparam int unsigned SCREEN_H     = 480;
   localparam logic [8:0]  DEFAULT_SEED = 9'h1A5;

   // x^9 + x^5 + 1, shifting right with feedback into bit 8
   function automatic logic [8:0] lfsr9_next(input logic [8:0] s);
      return {s[4] ^ s[0], s[8:1]};
   endfunction

endpackage

// File: rtl/lfsr9_seeded.sv
// Free-running 9-bit maximal-length LFSR with synchronous seed load
// and recovery from the all-zero lock-up state.
module lfsr9_seeded
   import flappy_pkg::*;
#(
   parameter logic [8:0] SEED = DEFAULT_SEED
) (
   input  logic       clock,
   input  logic       reset,
   output logic [8:0] state
);

   logic [8:0] state_d;
   logic [8:0] state_q;

   always_comb begin
      state_d = lfsr9_next(state_q);
      if (state_q == '0) begin
         state_d = SEED;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/pipe_gap_scheduler.sv
// Counts frames while the game runs and offers a random pipe gap row to the
// renderer every SPAWN_FRAMES frames over a valid/ready handshake.
module pipe_gap_scheduler
   import flappy_pkg::*;
#(
   parameter int unsigned SPAWN_FRAMES  = 90,
   parameter int unsigned GAP_MIN       = 40,
   parameter int unsigned GAP_SPAN_LOG2 = 8,
   parameter logic [8:0]  SEED          = DEFAULT_SEED
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               game_run,
   input  logic               spawn_ready,
   output logic               spawn_valid,
   output logic [GAP_Y_W-1:0] gap_y,
   output logic [7:0]         spawn_count,
   output logic               overrun,
   output logic [8:0]         lfsr_state
);

   localparam int unsigned     CNT_W    = $clog2(SPAWN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);

   if (SPAWN_FRAMES < 2) begin : g_bad_frames
      $error("SPAWN_FRAMES must be at least 2");
   end
   if (GAP_SPAN_LOG2 < 1 || GAP_SPAN_LOG2 > 8) begin : g_bad_span
      $error("GAP_SPAN_LOG2 must be in 1..8");
   end
   if (GAP_MIN + (2 ** GAP_SPAN_LOG2) > SCREEN_H) begin : g_bad_range
      $error("gap range exceeds screen height");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("SEED must be nonzero");
   end

   state_t               state_d,       state_q;
   logic [CNT_W-1:0]     frame_cnt_d,   frame_cnt_q;
   logic [GAP_Y_W-1:0]   gap_y_d,       gap_y_q;
   logic [7:0]           spawn_count_d, spawn_count_q;
   logic                 overrun_d,     overrun_q;

   logic [GAP_Y_W-1:0]   gap_capture;
   logic                 interval_done;
   logic                 handshake;

   lfsr9_seeded #(
      .SEED (SEED)
   ) u_lfsr (
      .clock (clock),
      .reset (reset),
      .state (lfsr_state)
   );

   assign gap_capture   = GAP_Y_W'(GAP_MIN) + GAP_Y_W'(lfsr_state[GAP_SPAN_LOG2-1:0]);
   assign interval_done = frame_tick && (frame_cnt_q == CNT_LAST);
   assign handshake     = (state_q == OFFER) && spawn_ready;

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      gap_y_d       = gap_y_q;
      spawn_count_d = spawn_count_q;
      overrun_d     = overrun_q;

      if (!game_run) begin
         // leaving play discards any pending offer without counting it
         state_d     = IDLE;
         frame_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               frame_cnt_d   = '0;
               state_d       = COUNT;
               spawn_count_d = '0;
               overrun_d     = 1'b0;
            end
            COUNT: begin
               if (frame_tick) begin
                  frame_cnt_d = interval_done ? '0 : frame_cnt_q + 1'b1;
               end
               if (interval_done) begin
                  gap_y_d = gap_capture;
                  state_d = OFFER;
               end
            end
            OFFER: begin
               if (frame_tick) begin
                  frame_cnt_d = interval_done ? '0 : frame_cnt_q + 1'b1;
               end
               if (handshake) begin
                  spawn_count_d = spawn_count_q + 8'd1;
                  if (interval_done) begin
                     gap_y_d = gap_capture;
                  end else begin
                     state_d = COUNT;
                  end
               end else if (interval_done) begin
                  overrun_d = 1'b1;
               end
            end
            default: begin
               state_d     = IDLE;
               frame_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         frame_cnt_q   <= '0;
         gap_y_q       <= '0;
         spawn_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         gap_y_q       <= gap_y_d;
         spawn_count_q <= spawn_count_d;
         overrun_q     <= overrun_d;
      end
   end

   assign spawn_valid = (state_q == OFFER);
   assign gap_y       = gap_y_q;
   assign spawn_count = spawn_count_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// Directed bench for pipe_gap_scheduler: an independent LFSR model feeds a
// queue of expected gap rows, which are checked while each offer is pending.
module tb_pipe_gap_scheduler;

   localparam logic [8:0] SEED_C = 9'h1A5;

   logic       clock = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       game_run;
   logic       spawn_ready;
   logic       spawn_valid;
   logic [9:0] gap_y;
   logic [7:0] spawn_count;
   logic       overrun;
   logic [8:0] lfsr_state;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   logic [8:0] model_lfsr;
   logic [9:0] sb_q[$];

   pipe_gap_scheduler #(
      .SPAWN_FRAMES  (3),
      .GAP_MIN       (40),
      .GAP_SPAN_LOG2 (8),
      .SEED          (SEED_C)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .game_run    (game_run),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .gap_y       (gap_y),
      .spawn_count (spawn_count),
      .overrun     (overrun),
      .lfsr_state  (lfsr_state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset || model_lfsr == 9'd0) begin
         model_lfsr <= SEED_C;
      end else begin
         model_lfsr <= {model_lfsr[4] ^ model_lfsr[0], model_lfsr[8:1]};
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) cyc();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // expected gap is taken from the LFSR value of the capturing cycle
   task automatic sb_push();
      sb_q.push_back(10'(10'd40 + 10'(model_lfsr[7:0])));
   endtask

   task automatic sb_accept();
      if (sb_q.size() > 0) void'(sb_q.pop_front());
   endtask

   task automatic check_gap(input string tag);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected <no queued offer>", tag, gap_y);
      end else begin
         check(tag, 32'(gap_y), 32'(sb_q[0]));
      end
   endtask

   task automatic do_tick(input bit qual);
      frame_tick = 1'b1;
      if (qual) sb_push();
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic restart_game();
      game_run = 1'b0;
      cyc();
      game_run = 1'b1;
      cyc();
   endtask

   initial begin
      bit zero_seen;
      bit early_repeat;

      reset       = 1'b1;
      frame_tick  = 1'b0;
      game_run    = 1'b0;
      spawn_ready = 1'b0;
      zero_seen    = 1'b0;
      early_repeat = 1'b0;

      // 1: reset values and LFSR period
      idle(2);
      reset = 1'b0;
      check("rst_lfsr",    32'(lfsr_state),  32'h1A5);
      check("rst_valid",   32'(spawn_valid), 32'h0);
      check("rst_gap",     32'(gap_y),       32'h0);
      check("rst_count",   32'(spawn_count), 32'h0);
      check("rst_overrun", 32'(overrun),     32'h0);
      cyc();
      check("lfsr_step1", 32'(lfsr_state), 32'h1D2);
      for (int i = 0; i < 510; i++) begin
         cyc();
         if (lfsr_state == 9'd0) zero_seen = 1'b1;
         if (i < 509 && lfsr_state == SEED_C) early_repeat = 1'b1;
      end
      check("lfsr_no_zero",      32'(zero_seen),    32'h0);
      check("lfsr_early_repeat", 32'(early_repeat), 32'h0);
      check("lfsr_period",       32'(lfsr_state),   32'h1A5);
      check("lfsr_model",        32'(lfsr_state),   32'(model_lfsr));

      // 2: always-ready renderer, tick every 4 cycles
      game_run    = 1'b1;
      spawn_ready = 1'b1;
      cyc();
      for (int i = 1; i <= 15; i++) begin
         if (i % 3 == 0) begin
            do_tick(1'b1);
            check("t2_valid", 32'(spawn_valid), 32'h1);
            check_gap("t2_gap");
            cyc();
            sb_accept();
            check("t2_valid_drop", 32'(spawn_valid), 32'h0);
            check("t2_count",      32'(spawn_count), 32'(i / 3));
            idle(2);
         end else begin
            do_tick(1'b0);
            check("t2_no_valid", 32'(spawn_valid), 32'h0);
            idle(3);
         end
      end
      check("t2_count_final", 32'(spawn_count), 32'd5);
      spawn_ready = 1'b0;

      // 3: unaccepted offer across a full interval
      restart_game();
      do_tick(1'b0); idle(3);
      do_tick(1'b0); idle(3);
      do_tick(1'b1);
      check("t3_valid", 32'(spawn_valid), 32'h1);
      check_gap("t3_gap");
      idle(3);
      for (int k = 1; k <= 4; k++) begin
         do_tick(1'b0);
         check_gap("t3_gap_hold");
         check("t3_valid_hold", 32'(spawn_valid), 32'h1);
         check("t3_overrun",    32'(overrun),     (k >= 3) ? 32'h1 : 32'h0);
         idle(3);
      end
      spawn_ready = 1'b1;
      cyc();
      sb_accept();
      spawn_ready = 1'b0;
      check("t3_count",        32'(spawn_count), 32'd1);
      check("t3_overrun_keep", 32'(overrun),     32'h1);
      check("t3_valid_drop",   32'(spawn_valid), 32'h0);

      // 4: handshake coinciding with interval expiry
      restart_game();
      do_tick(1'b0); idle(3);
      do_tick(1'b0); idle(3);
      do_tick(1'b1);
      check("t4_valid", 32'(spawn_valid), 32'h1);
      check_gap("t4_gap_first");
      idle(3);
      do_tick(1'b0); idle(3);
      do_tick(1'b0); idle(3);
      spawn_ready = 1'b1;
      do_tick(1'b1);
      spawn_ready = 1'b0;
      sb_accept();
      check("t4_count",      32'(spawn_count), 32'd1);
      check("t4_valid_stay", 32'(spawn_valid), 32'h1);
      check_gap("t4_gap_new");
      check("t4_overrun",    32'(overrun),     32'h0);

      // 5: drop play mid-offer, then restart
      game_run = 1'b0;
      cyc();
      sb_q.delete();
      check("t5_valid_drop", 32'(spawn_valid), 32'h0);
      check("t5_count_hold", 32'(spawn_count), 32'd1);
      idle(3);
      check("t5_count_idle", 32'(spawn_count), 32'd1);
      game_run = 1'b1;
      cyc();
      check("t5_count_clr",   32'(spawn_count), 32'd0);
      check("t5_overrun_clr", 32'(overrun),     32'h0);
      do_tick(1'b0); idle(3);
      do_tick(1'b0);
      check("t5_no_valid", 32'(spawn_valid), 32'h0);
      idle(3);
      do_tick(1'b1);
      check("t5_valid", 32'(spawn_valid), 32'h1);
      check_gap("t5_gap");

      // 6: reset while an offer is pending and ready is high
      spawn_ready = 1'b1;
      cyc();
      sb_accept();
      spawn_ready = 1'b0;
      check("t6_count_pre", 32'(spawn_count), 32'd1);
      idle(2);
      do_tick(1'b0); idle(3);
      do_tick(1'b0); idle(3);
      do_tick(1'b1);
      check("t6_valid", 32'(spawn_valid), 32'h1);
      check_gap("t6_gap");
      reset       = 1'b1;
      spawn_ready = 1'b1;
      cyc();
      sb_q.delete();
      check("t6_count",   32'(spawn_count), 32'd0);
      check("t6_valid",   32'(spawn_valid), 32'h0);
      check("t6_lfsr",    32'(lfsr_state),  32'h1A5);
      check("t6_gap",     32'(gap_y),       32'h0);
      check("t6_overrun", 32'(overrun),     32'h0);
      reset       = 1'b0;
      spawn_ready = 1'b0;
      cyc();
      check("t6_lfsr_step", 32'(lfsr_state), 32'h1D2);
      check("t6_lfsr_model", 32'(lfsr_state), 32'(model_lfsr));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_gap_scheduler.md
Name: pipe_gap_scheduler

Overview:
Schedules pipe spawns for the playfield. It owns a seeded 9-bit maximal-length LFSR, counts frame ticks while the game runs, and every SPAWN_FRAMES frames draws a random gap position. It offers that position to the pipe renderer over a valid/ready handshake. It sits between the game-state FSM (game_run, frame_tick) and the pipe object logic.

Parameters:
SPAWN_FRAMES, 90, frames between spawn offers (>=2)
GAP_MIN, 40, minimum gap_y in pixels
GAP_SPAN_LOG2, 8, gap_y = GAP_MIN + lfsr[GAP_SPAN_LOG2-1:0]; range 1..8
SEED, 9'h1A5, LFSR value loaded on reset; must be nonzero

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
game_run  in  1  high while play is active
spawn_ready  in  1  renderer accepts the offer
spawn_valid  out  1  a gap offer is pending
gap_y  out  10  gap top row; stable while spawn_valid
spawn_count  out  8  accepted spawns since game_run rose; wraps at 255
overrun  out  1  sticky: an interval elapsed while an offer was unaccepted
lfsr_state  out  9  current LFSR value (debug/test)

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clock. On reset: lfsr_state=SEED, state=IDLE, frame_cnt=0, spawn_valid=0, gap_y=0, spawn_count=0, overrun=0.
- LFSR steps every cycle outside reset, regardless of state:
  - next = {s[4]^s[0], s[8:1]} (x^9+x^5+1, period 511).
  - If the state is ever 0, it reloads SEED on the next cycle.
- The gap value is captured combinationally from the current lfsr_state in the capture cycle and registered: gap_y = GAP_MIN + zero-extended lfsr[GAP_SPAN_LOG2-1:0].
- IDLE:
  - spawn_valid=0, frame_cnt held at 0.
  - game_run=1 → COUNT, and spawn_count and overrun clear.
- COUNT:
  - On frame_tick, frame_cnt increments.
  - If frame_tick arrives with frame_cnt==SPAWN_FRAMES-1: frame_cnt←0, capture gap_y → OFFER. spawn_valid is high the following cycle (1-cycle latency from the qualifying tick).
- OFFER:
  - spawn_valid=1 and gap_y is held.
  - frame_cnt keeps counting on frame_tick, so the spawn interval stays fixed.
  - spawn_valid & spawn_ready → spawn_count++, and the block returns to COUNT.
  - If the interval elapses with no handshake that cycle: overrun←1, the new value is discarded, and the original offer is kept.
  - If the handshake and interval expiry coincide: the handshake completes (count++), a new gap_y is captured, the block stays in OFFER, and overrun is unchanged.
- game_run=0 in any state → IDLE next cycle:
  - spawn_valid drops and any pending offer is discarded (not counted).
  - spawn_count holds its value until the next game_run rise.
- spawn_ready while spawn_valid=0 is ignored.
- Reset mid-offer: all outputs return to their reset values in the next cycle; no handshake completes in the reset cycle.
- frame_cnt width is $clog2(SPAWN_FRAMES).

Decomposition:
- flappy_pkg holds:
  - the state enum {IDLE, COUNT, OFFER}
  - the GAP_Y_W=10 constant
  - SCREEN_H=480
  - the default SEED
- Sub-module lfsr9_seeded: free-running 9-bit LFSR with synchronous reset to a parameterised seed and lock-up recovery. It is instantiated once here.

Test Plan:
1. Assert reset 2 cycles, then release → lfsr_state=0x1A5 in the first cycle after release, 0x1D2 the next; outputs 0; 511 steps later lfsr_state=0x1A5 again, with no zero value in between.
2. SPAWN_FRAMES=3, game_run=1, frame_tick every 4 cycles, spawn_ready=1 → spawn_valid pulses one cycle after every 3rd tick; gap_y = 40 + lfsr[7:0] sampled at the capture cycle; spawn_count reaches 5 after 15 ticks.
3. spawn_ready=0 for 4 ticks after an offer (SPAWN_FRAMES=3) → gap_y unchanged throughout, overrun=1 after the 3rd tick; then ready=1 → spawn_count=1, overrun stays 1.
4. Offer pending and spawn_ready=1 coinciding with the interval-completing tick → spawn_count+1, spawn_valid stays high with the new gap_y, overrun=0.
5. Drop game_run while spawn_valid=1 → spawn_valid=0 next cycle, spawn_count unchanged. Raise game_run again → spawn_count=0, overrun=0, first offer after 3 ticks.
6. Assert reset during OFFER with spawn_ready=1 → spawn_count=0 and spawn_valid=0 after the reset edge, lfsr_state=0x1A5.
